// File: rtl/ext_domain_pwr_seq.sv
// ============================================================================
// Module      : ext_domain_pwr_seq
// Description : Power-gating sequencer for one external power domain. It drives
//               the switch, isolation, reset and clock-gate controls in a fixed
//               safe order and waits for the switch cell's acknowledge. It also
//               flags acknowledge timeouts.
//               Optional retention path: define PWR_SEQ_RETENTION_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ext_domain_pwr_seq #(
  parameter int unsigned STEP_CYCLES = 2,
  parameter int unsigned ACK_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pwr_en_i,
  input  logic err_clr_i,
  input  logic switch_ack_ni,
`ifdef PWR_SEQ_RETENTION_EN
  input  logic ret_en_i,
  output logic ram_banks_set_retentive_no,
`endif
  output logic switch_no,
  output logic iso_no,
  output logic rst_no,
  output logic clkgate_en_no,
  output logic busy_o,
  output logic pwr_on_o,
  output logic pwr_off_o,
  output logic timeout_err_o
);

  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
  localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ACK_SAT   = CNT_W'(ACK_TIMEOUT);

  typedef enum logic [3:0] {
    ST_ON          = 4'd0,
    ST_OFF_CG      = 4'd1,
    ST_OFF_ISO     = 4'd2,
    ST_OFF_RST     = 4'd3,
    ST_OFF_SW_WAIT = 4'd4,
    ST_OFF         = 4'd5,
    ST_ON_SW_WAIT  = 4'd6,
    ST_ON_RST      = 4'd7,
`ifdef PWR_SEQ_RETENTION_EN
    ST_RET         = 4'd9,
`endif
    ST_ON_ISO      = 4'd8
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             ack_meta;
  logic             ack_s;
  logic             step_done;
  logic             in_wait;
  logic             in_step;
  logic             timeout_set;

  logic             switch_nxt;
  logic             iso_nxt;
  logic             rst_nxt;
  logic             cg_nxt;
  logic             busy_nxt;
  logic             pwr_on_nxt;
  logic             pwr_off_nxt;

`ifdef PWR_SEQ_RETENTION_EN
  logic             ret_mode;
  logic             ret_mode_nxt;
  logic             ret_no_nxt;
`endif

  // Two-flop synchroniser for the asynchronous switch acknowledge
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_meta <= 1'b0;
      ack_s    <= 1'b0;
    end else begin
      ack_meta <= switch_ack_ni;
      ack_s    <= ack_meta;
    end
  end

  // Next-state selection and decode of the outputs for the next state
  always_comb begin
    state_nxt   = state;
    step_done   = (cnt == STEP_LAST);
    in_wait     = (state == ST_OFF_SW_WAIT) || (state == ST_ON_SW_WAIT);
    in_step     = (state == ST_OFF_CG) || (state == ST_OFF_ISO) ||
                  (state == ST_OFF_RST) || (state == ST_ON_RST) ||
                  (state == ST_ON_ISO);
`ifdef PWR_SEQ_RETENTION_EN
    ret_mode_nxt = ret_mode;
`endif

    case (state)
      ST_ON: begin
        if (!pwr_en_i) begin
          state_nxt = ST_OFF_CG;
`ifdef PWR_SEQ_RETENTION_EN
          ret_mode_nxt = ret_en_i;
`endif
        end
      end
      ST_OFF_CG:      if (step_done) state_nxt = ST_OFF_ISO;
      ST_OFF_ISO: begin
        if (step_done) begin
`ifdef PWR_SEQ_RETENTION_EN
          state_nxt = ret_mode ? ST_RET : ST_OFF_RST;
`else
          state_nxt = ST_OFF_RST;
`endif
        end
      end
      ST_OFF_RST:     if (step_done) state_nxt = ST_OFF_SW_WAIT;
      ST_OFF_SW_WAIT: if (ack_s) state_nxt = ST_OFF;
      ST_OFF:         if (pwr_en_i) state_nxt = ST_ON_SW_WAIT;
      ST_ON_SW_WAIT:  if (!ack_s) state_nxt = ST_ON_RST;
      ST_ON_RST:      if (step_done) state_nxt = ST_ON_ISO;
      ST_ON_ISO:      if (step_done) state_nxt = ST_ON;
`ifdef PWR_SEQ_RETENTION_EN
      ST_RET:         if (pwr_en_i) state_nxt = ST_ON_ISO;
`endif
      default:        state_nxt = ST_ON;
    endcase

    // Timeout fires once, on the last count of a wait that is not ending
    timeout_set = ((state == ST_OFF_SW_WAIT) && !ack_s ||
                   (state == ST_ON_SW_WAIT)  &&  ack_s) &&
                  (cnt == ACK_LAST);

    switch_nxt  = 1'b0;
    iso_nxt     = 1'b1;
    rst_nxt     = 1'b1;
    cg_nxt      = 1'b1;
    case (state_nxt)
      ST_ON:          begin switch_nxt = 1'b0; iso_nxt = 1'b1; rst_nxt = 1'b1; cg_nxt = 1'b1; end
      ST_OFF_CG:      begin switch_nxt = 1'b0; iso_nxt = 1'b1; rst_nxt = 1'b1; cg_nxt = 1'b0; end
      ST_OFF_ISO:     begin switch_nxt = 1'b0; iso_nxt = 1'b0; rst_nxt = 1'b1; cg_nxt = 1'b0; end
      ST_OFF_RST:     begin switch_nxt = 1'b0; iso_nxt = 1'b0; rst_nxt = 1'b0; cg_nxt = 1'b0; end
      ST_OFF_SW_WAIT: begin switch_nxt = 1'b1; iso_nxt = 1'b0; rst_nxt = 1'b0; cg_nxt = 1'b0; end
      ST_OFF:         begin switch_nxt = 1'b1; iso_nxt = 1'b0; rst_nxt = 1'b0; cg_nxt = 1'b0; end
      ST_ON_SW_WAIT:  begin switch_nxt = 1'b0; iso_nxt = 1'b0; rst_nxt = 1'b0; cg_nxt = 1'b0; end
      ST_ON_RST:      begin switch_nxt = 1'b0; iso_nxt = 1'b0; rst_nxt = 1'b1; cg_nxt = 1'b0; end
      ST_ON_ISO:      begin switch_nxt = 1'b0; iso_nxt = 1'b1; rst_nxt = 1'b1; cg_nxt = 1'b0; end
`ifdef PWR_SEQ_RETENTION_EN
      // Domain stays powered and out of reset; RAM banks hold their contents
      ST_RET:         begin switch_nxt = 1'b0; iso_nxt = 1'b0; rst_nxt = 1'b1; cg_nxt = 1'b0; end
`endif
      default:        begin switch_nxt = 1'b0; iso_nxt = 1'b1; rst_nxt = 1'b1; cg_nxt = 1'b1; end
    endcase

`ifdef PWR_SEQ_RETENTION_EN
    ret_no_nxt  = (state_nxt != ST_RET);
    pwr_off_nxt = (state_nxt == ST_OFF) || (state_nxt == ST_RET);
    busy_nxt    = (state_nxt != ST_ON) && (state_nxt != ST_OFF) && (state_nxt != ST_RET);
`else
    pwr_off_nxt = (state_nxt == ST_OFF);
    busy_nxt    = (state_nxt != ST_ON) && (state_nxt != ST_OFF);
`endif
    pwr_on_nxt  = (state_nxt == ST_ON);
  end

  // State register with outputs registered alongside it
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= ST_ON;
      switch_no     <= 1'b0;
      iso_no        <= 1'b1;
      rst_no        <= 1'b1;
      clkgate_en_no <= 1'b1;
      busy_o        <= 1'b0;
      pwr_on_o      <= 1'b1;
      pwr_off_o     <= 1'b0;
    end else begin
      state         <= state_nxt;
      switch_no     <= switch_nxt;
      iso_no        <= iso_nxt;
      rst_no        <= rst_nxt;
      clkgate_en_no <= cg_nxt;
      busy_o        <= busy_nxt;
      pwr_on_o      <= pwr_on_nxt;
      pwr_off_o     <= pwr_off_nxt;
    end
  end

`ifdef PWR_SEQ_RETENTION_EN
  // Remembers which power-down flavour was chosen when ON was left
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ret_mode                   <= 1'b0;
      ram_banks_set_retentive_no <= 1'b1;
    end else begin
      ret_mode                   <= ret_mode_nxt;
      ram_banks_set_retentive_no <= ret_no_nxt;
    end
  end
`endif

  // Step / wait counter: restarts on every state change, saturates while waiting
  always_ff @(posedge clk_i) begin
    if (rst_i || (state_nxt != state)) begin
      cnt <= '0;
    end else if (in_wait) begin
      if (cnt != ACK_SAT) cnt <= cnt + CNT_W'(1);
    end else if (in_step) begin
      cnt <= cnt + CNT_W'(1);
    end else begin
      cnt <= '0;
    end
  end

  // Sticky timeout flag; a new timeout outranks a simultaneous clear
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      timeout_err_o <= 1'b0;
    end else if (timeout_set) begin
      timeout_err_o <= 1'b1;
    end else if (err_clr_i) begin
      timeout_err_o <= 1'b0;
    end
  end

endmodule

`default_nettype wire
